la_clkgatectrl: RTL and testbench
=================================

LA_CLKGATECTRL -- requirements
Module: la_clkgatectrl

Interface
REQ-001 Parameter PROP, default "DEFAULT": implementation property string, passed through unused.
REQ-002 Parameter IDLEW, default 8: width of the idle counter and of idle_thresh.
REQ-003 Parameter WAKEDLY, default 2 (legal range 1..15): cycles en is held high in WAKE before the clock counts as running.
REQ-004 Port clk, input, 1: free-running (ungated) clock; all state is updated on its rising edge.
REQ-005 Port reset, input, 1: asynchronous reset, active-high.
REQ-006 Port busy, input, 1: activity indication from the gated domain.
REQ-007 Port wake_req, input, 1: wake request; the requester holds it high until wake_ack.
REQ-008 Port force_on, input, 1: inhibits gating while high.
REQ-009 Port idle_thresh, input, IDLEW: number of consecutive idle cycles required before gating; 0 disables gating.
REQ-010 Port en, output, 1: registered enable driving the en input of the downstream integrated AND clock-gate cell.
REQ-011 Port wake_ack, output, 1: single-cycle acknowledge of wake_req.
REQ-012 Port gated, output, 1: high while the state is GATED.

Function
REQ-013 Define idle = ~busy & ~wake_req & ~force_on, sampled each rising clk edge.
REQ-014 The block SHALL implement three states: RUN, GATED and WAKE.
REQ-015 In RUN, en SHALL be 1.
- idle high: idle counter cnt increments, saturating at all-ones.
- idle low: cnt clears to 0.
REQ-016 In RUN, when idle is high, idle_thresh != 0 and cnt+1 >= idle_thresh, the next state SHALL be GATED, with en=0 and gated=1 from that edge; cnt clears.
REQ-017 idle_thresh SHALL be compared live; lowering it below cnt mid-count gates on the next idle cycle.
REQ-018 In GATED, en SHALL be 0; any of busy, wake_req or force_on high SHALL move the block to WAKE at the same edge, with en=1 registered.
REQ-019 In WAKE, en SHALL be 1; a wake counter SHALL run WAKEDLY cycles, then the state becomes RUN with cnt=0; busy and idle are ignored while in WAKE.
REQ-020 For a wake_req that caused GATED->WAKE, wake_ack SHALL pulse high for exactly the first cycle of RUN after WAKE.
REQ-021 For a wake_req arriving in RUN, wake_ack SHALL pulse high in the cycle after the edge sampling wake_req.
REQ-022 Exactly one wake_ack SHALL be issued per request; an internal ack_done flag sets on the ack and clears when wake_req is sampled low.
REQ-023 A wake_req still held after the ack SHALL count as non-idle and SHALL NOT produce a second ack.
REQ-024 If wake_req rises during WAKE, its ack SHALL be the same RUN-entry pulse.
REQ-025 en SHALL be a direct flop output with no combinational path from inputs, so it is stable while clk is low at the ICG latch.

Reset
REQ-026 Asserting reset SHALL immediately force the following, regardless of state: state=RUN, en=1, cnt=0, wake counter=0, ack_done=0, wake_ack=0, gated=0.
REQ-027 Deassertion SHALL be synchronized externally; the first active edge after release behaves as RUN with cnt=0.
REQ-028 Reset asserted while GATED SHALL re-enable the clock (en=1) without waiting for clk.

Structure
REQ-029 State encodings (RUN=2'b00, GATED=2'b01, WAKE=2'b10) SHALL live in a shared package/header la_clkgate_pkg, together with the default WAKEDLY.
REQ-030 The saturating idle counter with live threshold compare SHALL be one sub-module, la_clkgatectrl_cnt.
REQ-031 The wake-delay counter SHALL be inline, 4 bits wide.

Verification
REQ-032 Reset release, then idle_thresh=4 with all inputs low: en falls after the 4th idle edge, gated=1; no wake_ack.
REQ-033 idle_thresh=4, busy pulsed at the 3rd idle cycle: cnt clears, and en stays 1 until 4 further idle cycles.
REQ-034 GATED, then wake_req raised at edge t with WAKEDLY=2: en=1 at t, wake_ack=1 during the cycle after t+2, exactly once; held wake_req keeps en=1.
REQ-035 RUN, wake_req raised: wake_ack pulses next cycle; wake_req held 10 cycles gives no second ack; drop and re-raise gives a new ack.
REQ-036 idle_thresh=0 or force_on=1 for 300 idle cycles: en stays 1; cnt saturates at 255 without wrap.
REQ-037 reset asserted mid-GATED between clk edges: en=1 and gated=0 asynchronously; after release the block is in RUN with cnt=0.

Source files
------------

// File: rtl/la_clkgate_pkg.sv
// Shared definitions for the clock-gate controller: state encodings and
// wake-delay defaults.
package la_clkgate_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_GATED = 2'b01,
    ST_WAKE  = 2'b10
  } state_t;

  localparam int WAKEDLY_DEF = 2;
  localparam int WCNTW       = 4;

endpackage

// File: rtl/la_clkgatectrl_cnt.sv
// Saturating idle counter with a live threshold compare; hit flags the idle
// cycle on which gating should start.
module la_clkgatectrl_cnt #(
  parameter int IDLEW = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run_idle,
  input  logic [IDLEW-1:0] thresh,
  output logic             hit
);

  logic [IDLEW-1:0] cnt;
  logic [IDLEW:0]   cnt_inc;

  // One extra bit so cnt+1 cannot wrap before the compare.
  assign cnt_inc = {1'b0, cnt} + {{IDLEW{1'b0}}, 1'b1};
  assign hit     = run_idle && (thresh != '0) && (cnt_inc >= {1'b0, thresh});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (run_idle && !hit) begin
      cnt <= (&cnt) ? cnt : cnt_inc[IDLEW-1:0];
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/la_clkgatectrl.sv
// Clock-gate controller: drops the ICG enable after a run of idle cycles and
// brings it back on activity, acknowledging wake requests once each.
module la_clkgatectrl
  import la_clkgate_pkg::*;
#(
  parameter        PROP    = "DEFAULT",
  parameter int    IDLEW   = 8,
  parameter int    WAKEDLY = WAKEDLY_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             busy,
  input  logic             wake_req,
  input  logic             force_on,
  input  logic [IDLEW-1:0] idle_thresh,
  output logic             en,
  output logic             wake_ack,
  output logic             gated
);

  localparam logic [WCNTW-1:0] WAKE_LAST = WCNTW'(WAKEDLY - 1);

  state_t           state, state_nxt;
  logic [WCNTW-1:0] wcnt, wcnt_nxt;
  logic             idle, run_idle, hit, wake_done, ack_set, ack_done;

  assign idle      = ~busy & ~wake_req & ~force_on;
  assign run_idle  = (state == ST_RUN) && idle;
  assign wake_done = (state == ST_WAKE) && (wcnt == WAKE_LAST);
  // A request is acked on the RUN cycle that sees it, or on WAKE exit.
  assign ack_set   = wake_req && !ack_done && ((state == ST_RUN) || wake_done);
  assign gated     = (state == ST_GATED);

  la_clkgatectrl_cnt #(
    .IDLEW (IDLEW)
  ) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .run_idle (run_idle),
    .thresh   (idle_thresh),
    .hit      (hit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_RUN;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = '0;
    case (state)
      ST_RUN: begin
        if (hit) state_nxt = ST_GATED;
      end
      ST_GATED: begin
        if (!idle) state_nxt = ST_WAKE;
      end
      ST_WAKE: begin
        if (wcnt == WAKE_LAST) state_nxt = ST_RUN;
        else                   wcnt_nxt  = wcnt + 1'b1;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  // en is its own flop so the ICG latch never sees a combinational path.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en       <= 1'b1;
      wake_ack <= 1'b0;
      ack_done <= 1'b0;
    end else begin
      en       <= (state_nxt != ST_GATED);
      wake_ack <= ack_set;
      ack_done <= wake_req ? (ack_done | ack_set) : 1'b0;
    end
  end

endmodule

// File: tb/tb_la_clkgatectrl.sv
// Directed bench for la_clkgatectrl: a per-cycle vector table plus
// hand-written saturation, force_on and asynchronous-reset sequences.
module tb_la_clkgatectrl;

  logic       clk, reset, busy, wake_req, force_on;
  logic [7:0] idle_thresh;
  logic       en, wake_ack, gated;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       busy;
    logic       wake_req;
    logic       force_on;
    logic [7:0] th;
    logic       en;
    logic       gated;
    logic       ack;
  } vec_t;

  vec_t vecs[$];

  la_clkgatectrl #(
    .PROP    ("DEFAULT"),
    .IDLEW   (8),
    .WAKEDLY (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .busy        (busy),
    .wake_req    (wake_req),
    .force_on    (force_on),
    .idle_thresh (idle_thresh),
    .en          (en),
    .wake_ack    (wake_ack),
    .gated       (gated)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input int n, input logic b, input logic w, input logic f,
                     input logic [7:0] th, input logic e, input logic g, input logic a);
    vec_t v;
    v.busy = b; v.wake_req = w; v.force_on = f; v.th = th;
    v.en = e; v.gated = g; v.ack = a;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    busy = 1'b0; wake_req = 1'b0; force_on = 1'b0;
    #2;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    busy = 1'b0; wake_req = 1'b0; force_on = 1'b0;
    idle_thresh = 8'd4;

    //   n  b  w  f  th  en g  ack
    add(3,  0, 0, 0, 4,  1, 0, 0);  // idle count 1..3
    add(2,  0, 0, 0, 4,  0, 1, 0);  // gated on 4th idle edge
    add(2,  0, 1, 0, 4,  1, 0, 0);  // wake_req -> WAKE, two cycles
    add(1,  0, 1, 0, 4,  1, 0, 1);  // RUN entry ack
    add(2,  0, 1, 0, 4,  1, 0, 0);  // held, no second ack
    add(3,  0, 0, 0, 4,  1, 0, 0);
    add(1,  0, 0, 0, 4,  0, 1, 0);
    add(1,  1, 0, 0, 4,  1, 0, 0);  // busy wakes
    add(4,  0, 0, 0, 4,  1, 0, 0);  // WAKE x2, RUN, cnt1, cnt2
    add(1,  1, 0, 0, 4,  1, 0, 0);  // busy on 3rd idle cycle clears cnt
    add(3,  0, 0, 0, 4,  1, 0, 0);
    add(1,  0, 0, 0, 4,  0, 1, 0);  // 4th idle after busy
    add(3,  0, 0, 1, 4,  1, 0, 0);  // force_on wakes, back in RUN
    add(1,  0, 1, 0, 4,  1, 0, 1);  // wake_req in RUN acked next cycle
    add(9,  0, 1, 0, 4,  1, 0, 0);  // held 10 cycles total
    add(1,  0, 0, 0, 4,  1, 0, 0);  // drop
    add(1,  0, 1, 0, 4,  1, 0, 1);  // re-raise -> new ack
    add(1,  0, 1, 0, 4,  1, 0, 0);
    add(3,  0, 0, 0, 4,  1, 0, 0);
    add(1,  0, 0, 0, 4,  0, 1, 0);
    add(1,  1, 0, 0, 4,  1, 0, 0);  // busy -> WAKE
    add(1,  0, 1, 0, 4,  1, 0, 0);  // wake_req rises during WAKE
    add(1,  0, 1, 0, 4,  1, 0, 1);  // acked on RUN entry
    add(1,  0, 1, 0, 4,  1, 0, 0);
    add(1,  0, 0, 0, 4,  1, 0, 0);  // cnt1
    add(3,  0, 0, 0, 10, 1, 0, 0);  // cnt2..4
    add(1,  0, 0, 0, 2,  0, 1, 0);  // live threshold lowered below cnt

    #2;
    chk("reset_en", en, 1'b1);
    chk("reset_gated", gated, 1'b0);
    chk("reset_ack", wake_ack, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      busy = vecs[i].busy; wake_req = vecs[i].wake_req;
      force_on = vecs[i].force_on; idle_thresh = vecs[i].th;
      step();
      chk($sformatf("vec%0d_en", i), en, vecs[i].en);
      chk($sformatf("vec%0d_gated", i), gated, vecs[i].gated);
      chk($sformatf("vec%0d_ack", i), wake_ack, vecs[i].ack);
    end

    // Threshold 0: no gating, counter saturates rather than wraps.
    do_reset();
    idle_thresh = 8'd0;
    for (int i = 0; i < 300; i++) begin
      step();
      chk($sformatf("thr0_en_%0d", i), en, 1'b1);
    end
    chk("sat_cnt", dut.u_cnt.cnt, 8'd255);
    idle_thresh = 8'd200;
    step();
    chk("sat_gate_en", en, 1'b0);
    chk("sat_gate_gated", gated, 1'b1);

    // force_on held: never gates, counter held at zero.
    do_reset();
    idle_thresh = 8'd4;
    force_on = 1'b1;
    for (int i = 0; i < 300; i++) begin
      step();
      chk($sformatf("force_en_%0d", i), en, 1'b1);
    end
    force_on = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("force_rel_en_%0d", i), en, 1'b1);
    end
    step();
    chk("force_rel_gate", en, 1'b0);

    // Reset between edges while GATED re-enables asynchronously.
    do_reset();
    idle_thresh = 8'd1;
    step();
    chk("ar_pre_en", en, 1'b0);
    chk("ar_pre_gated", gated, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_en", en, 1'b1);
    chk("ar_gated", gated, 1'b0);
    chk("ar_ack", wake_ack, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    idle_thresh = 8'd2;
    step();
    chk("ar_post1_en", en, 1'b1);
    step();
    chk("ar_post2_en", en, 1'b0);
    chk("ar_post2_gated", gated, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
